// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared FSM states, memory mode and request size encodings
package mem_access_unit_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;
  localparam logic [2:0] MODE_IDLE = 3'd0;
  localparam logic [2:0] MODE_BYTE = 3'd1;
  localparam logic [2:0] MODE_WORD = 3'd2;
  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;
endpackage

// File: rtl/mem_access_unit_load_extend.sv
// load_extend: combinational load-data extension.
// Ports: raw (memory read data), size (0 byte / 1 word), is_unsigned
// (zero-extend byte loads), ext (extended result; words pass through).
module load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] raw,
  input  logic        size,
  input  logic        is_unsigned,
  output logic [31:0] ext
);
  assign ext = (size == SIZE_WORD) ? raw : {{24{raw[7] & ~is_unsigned}}, raw[7:0]};
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-request CPU load/store unit driving a simple memory port.
// Ports: clk, reset (async active-low); req_* CPU request with req_ready handshake;
// resp_valid/resp_rdata/resp_err one-cycle completion; mem_* memory beat interface.
// TIMEOUT bounds the wait for mem_ready on each beat.
// Macro MEM_UNALIGNED_SPLIT_EN: misaligned words run as four byte beats instead of
// returning an error.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_mode,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);
  import mem_access_unit_pkg::*;
  state_e state_q, state_d;
  logic write_q, write_d, size_q, size_d, uns_q, uns_d, err_q, err_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [15:0] wait_q, wait_d;
  logic [31:0] ext_rdata, beat_addr;
  logic [7:0] beat_byte;
  logic acc, misaligned, timeout, last_beat, beat_word;
  assign misaligned = (req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00);
  // the final waiting cycle: mem_ready still wins here, only its absence times out
  assign timeout = wait_q == 16'(TIMEOUT - 1);
`ifdef MEM_UNALIGNED_SPLIT_EN
  logic split_q, split_d;
  logic [1:0] beat_q, beat_d;
  assign last_beat = !split_q || beat_q == 2'd3;
  assign beat_word = !split_q && size_q == SIZE_WORD;
  assign beat_addr = addr_q + {30'b0, beat_q};
  assign beat_byte = split_q ? wdata_q[{beat_q, 3'b000} +: 8] : wdata_q[7:0];
`else
  assign last_beat = 1'b1;
  assign beat_word = size_q == SIZE_WORD;
  assign beat_addr = addr_q;
  assign beat_byte = wdata_q[7:0];
`endif
  load_extend u_load_extend (
    .raw        (mem_rdata),
    .size       (size_q),
    .is_unsigned(uns_q),
    .ext        (ext_rdata)
  );
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    wait_d  = wait_q;
`ifdef MEM_UNALIGNED_SPLIT_EN
    split_d = split_q;
    beat_d  = beat_q;
`endif
    case (state_q)
      ST_IDLE: if (req_valid) begin
        write_d = req_write;
        size_d  = req_size;
        uns_d   = req_unsigned;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        rdata_d = '0;
        wait_d  = '0;
`ifdef MEM_UNALIGNED_SPLIT_EN
        split_d = misaligned;
        beat_d  = '0;
        err_d   = 1'b0;
        state_d = ST_ACCESS;
`else
        err_d   = misaligned;
        state_d = misaligned ? ST_RESP : ST_ACCESS;
`endif
      end
      ST_ACCESS: if (mem_ready) begin
        wait_d = '0;
`ifdef MEM_UNALIGNED_SPLIT_EN
        // split loads assemble little-endian, one byte lane per beat
        if (!write_q && split_q) rdata_d[{beat_q, 3'b000} +: 8] = mem_rdata[7:0];
        else if (!write_q) rdata_d = ext_rdata;
        beat_d = beat_q + 2'd1;
`else
        if (!write_q) rdata_d = ext_rdata;
`endif
        if (last_beat) state_d = ST_RESP;
      end else if (timeout) begin
        err_d   = 1'b1;
        rdata_d = '0;
        state_d = ST_RESP;
      end else begin
        wait_d = wait_q + 16'd1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      size_q  <= 1'b0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      wait_q  <= '0;
`ifdef MEM_UNALIGNED_SPLIT_EN
      split_q <= 1'b0;
      beat_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      wait_q  <= wait_d;
`ifdef MEM_UNALIGNED_SPLIT_EN
      split_q <= split_d;
      beat_q  <= beat_d;
`endif
    end
  end
  // outputs decode straight from state so reset drops strobes without a clock edge
  assign acc        = state_q == ST_ACCESS;
  assign req_ready  = reset && state_q == ST_IDLE;
  assign resp_valid = state_q == ST_RESP;
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign resp_err   = resp_valid && err_q;
  assign mem_mode   = !acc ? MODE_IDLE : beat_word ? MODE_WORD : MODE_BYTE;
  assign mem_read   = acc && !write_q;
  assign mem_write  = acc && write_q;
  assign mem_addr   = acc ? beat_addr : '0;
  assign mem_wdata  = !acc ? '0 : beat_word ? wdata_q : {24'b0, beat_byte};
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit (TIMEOUT = 4)
module tb_mem_access_unit;
  logic clk, reset, req_valid, req_ready, req_write, req_size, req_unsigned;
  logic [31:0] req_addr, req_wdata, resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic resp_valid, resp_err, mem_write, mem_read, mem_ready;
  logic [2:0] mem_mode;
  int n_vec = 0;
  int n_err = 0;
  int lat, nb;
  logic [31:0] r_data;
  logic r_err, resp_strobe, saw;
  logic [31:0] ba [8];
  logic [31:0] bd [8];
  logic [2:0] bm [8];
  logic bwr [8];

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_mode(mem_mode), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // one request; memory answers after dly wait cycles per beat; rd_pat makes
  // byte data depend on address (addr[7:0] + 0x10, upper bits set)
  task automatic xfer(input logic wr, input logic sz, input logic un, input logic [31:0] a,
                      input logic [31:0] wd, input int dly, input logic [31:0] rd, input bit rd_pat);
    int bw;
    bw = 0;
    nb = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = un;
    req_addr = a; req_wdata = wd; mem_ready = 1'b0;
    check("accept_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      if (mem_read || mem_write) begin
        mem_ready = bw >= dly;
        mem_rdata = rd_pat ? {24'hFFFFFF, mem_addr[7:0] + 8'h10} : rd;
        if (mem_ready) begin
          if (nb < 8) begin
            ba[nb] = mem_addr; bd[nb] = mem_wdata; bm[nb] = mem_mode; bwr[nb] = mem_write;
          end
          nb++;
          bw = 0;
        end else bw++;
      end else mem_ready = 1'b0;
      @(negedge clk);
      lat++;
    end
    mem_ready = 1'b0;
    r_data = resp_rdata;
    r_err = resp_err;
    resp_strobe = mem_read | mem_write | (mem_mode != 3'd0);
    check("resp_seen", resp_valid, 1);
    @(negedge clk);
    check("resp_one_cycle", resp_valid, 0);
    check("ready_back", req_ready, 1);
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 1'b0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
    #12;
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_mem_mode", mem_mode, 0);
    check("rst_strobes", {mem_read, mem_write}, 0);
    check("rst_mem_addr", mem_addr, 0);
    @(negedge clk); reset = 1'b1; #1;
    check("ready_after_release", req_ready, 1);

    xfer(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 0, 32'hDEADBEEF, 1'b0);
    check("lw_lat", lat, 2);
    check("lw_rdata", r_data, 32'hDEADBEEF);
    check("lw_err", r_err, 0);
    check("lw_beats", nb, 1);
    check("lw_addr", ba[0], 32'h100);
    check("lw_mode", bm[0], 2);
    check("lw_is_read", bwr[0], 0);

    xfer(1'b0, 1'b0, 1'b0, 32'h7, 32'h0, 0, 32'h12345680, 1'b0);
    check("lb_signed", r_data, 32'hFFFFFF80);
    check("lb_mode", bm[0], 1);
    check("lb_addr", ba[0], 32'h7);
    xfer(1'b0, 1'b0, 1'b1, 32'h7, 32'h0, 0, 32'h12345680, 1'b0);
    check("lbu", r_data, 32'h00000080);
    xfer(1'b0, 1'b0, 1'b0, 32'h6, 32'h0, 0, 32'hFFFFFF7F, 1'b0);
    check("lb_pos", r_data, 32'h0000007F);

    xfer(1'b1, 1'b0, 1'b0, 32'h3, 32'hAABBCCDD, 0, 32'h0, 1'b0);
    check("sb_wdata", bd[0], 32'h000000DD);
    check("sb_write", bwr[0], 1);
    check("sb_rdata", r_data, 0);
    check("sb_lat", lat, 2);

    xfer(1'b1, 1'b1, 1'b0, 32'h40, 32'h01020304, 1, 32'h0, 1'b0);
    check("sw_wait_lat", lat, 3);
    check("sw_wdata", bd[0], 32'h01020304);

    xfer(1'b1, 1'b1, 1'b0, 32'h202, 32'h11223344, 0, 32'h0, 1'b0);
`ifdef MEM_UNALIGNED_SPLIT_EN
    check("split_sw_beats", nb, 4);
    check("split_sw_lat", lat, 5);
    check("split_sw_err", r_err, 0);
    check("split_a0", ba[0], 32'h202); check("split_d0", bd[0], 32'h44);
    check("split_a1", ba[1], 32'h203); check("split_d1", bd[1], 32'h33);
    check("split_a2", ba[2], 32'h204); check("split_d2", bd[2], 32'h22);
    check("split_a3", ba[3], 32'h205); check("split_d3", bd[3], 32'h11);
    check("split_mode", bm[3], 1);
    xfer(1'b0, 1'b1, 1'b0, 32'h101, 32'h0, 0, 32'h0, 1'b1);
    check("split_lw", r_data, 32'h14131211);
    xfer(1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h0, 0, 32'h0, 1'b1);
    check("split_wrap_a1", ba[1], 32'h0);
    check("split_wrap_data", r_data, 32'h1211100F);
    xfer(1'b0, 1'b1, 1'b0, 32'h301, 32'h0, 9, 32'h0, 1'b1);
    check("split_to_err", r_err, 1);
    check("split_to_beats", nb, 0);
    check("split_to_rdata", r_data, 0);
`else
    check("mis_sw_beats", nb, 0);
    check("mis_sw_lat", lat, 1);
    check("mis_sw_err", r_err, 1);
    check("mis_sw_strobe", resp_strobe, 0);
    xfer(1'b0, 1'b1, 1'b0, 32'h101, 32'h0, 0, 32'hFFFFFFFF, 1'b0);
    check("mis_lw_err", r_err, 1);
    check("mis_lw_rdata", r_data, 0);
`endif

    xfer(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 9, 32'hDEADBEEF, 1'b0);
    check("to_err", r_err, 1);
    check("to_rdata", r_data, 0);
    check("to_lat", lat, 5);
    check("to_strobe_resp", resp_strobe, 0);
    xfer(1'b0, 1'b1, 1'b0, 32'h104, 32'h0, 3, 32'hCAFEBABE, 1'b0);
    check("to_edge_err", r_err, 0);
    check("to_edge_rdata", r_data, 32'hCAFEBABE);
    check("to_edge_lat", lat, 5);

    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 1'b1; req_addr = 32'h10;
    req_wdata = 32'hCAFEF00D; mem_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_write_on", mem_write, 1);
    #2 reset = 1'b0;
    #1;
    check("abort_write_off", mem_write, 0);
    check("abort_mode_off", mem_mode, 0);
    check("abort_ready_low", req_ready, 0);
    @(negedge clk);
    check("abort_no_resp", resp_valid, 0);
    reset = 1'b1;
    #1;
    check("abort_ready_release", req_ready, 1);
    saw = 1'b0;
    repeat (3) begin
      @(negedge clk);
      saw = saw | resp_valid;
    end
    check("abort_no_late_resp", saw, 0);
    xfer(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 0, 32'h0BADF00D, 1'b0);
    check("post_abort_lw", r_data, 32'h0BADF00D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
